// File: rtl/sc_level_tick_scheduler_if.sv
// Level/run inputs and tick/banner/period outputs between the progress counter,
// the tick scheduler and the lane movers/HUD.
interface sc_level_tick_scheduler_if #(
    parameter int unsigned LEVEL_DATAWIDTH = 5,
    parameter int unsigned PERIOD_WIDTH    = 26
);
    logic [LEVEL_DATAWIDTH-1:0] SC_LEVELTICKSCHEDULER_Level_InBus;
    logic                       SC_LEVELTICKSCHEDULER_Run_in;
    logic                       SC_LEVELTICKSCHEDULER_MoveTick_out;
    logic                       SC_LEVELTICKSCHEDULER_LevelUp_out;
    logic                       SC_LEVELTICKSCHEDULER_Banner_out;
    logic [PERIOD_WIDTH-1:0]    SC_LEVELTICKSCHEDULER_Period_OutBus;

    modport master (
        output SC_LEVELTICKSCHEDULER_Level_InBus,
        output SC_LEVELTICKSCHEDULER_Run_in,
        input  SC_LEVELTICKSCHEDULER_MoveTick_out,
        input  SC_LEVELTICKSCHEDULER_LevelUp_out,
        input  SC_LEVELTICKSCHEDULER_Banner_out,
        input  SC_LEVELTICKSCHEDULER_Period_OutBus
    );

    modport slave (
        input  SC_LEVELTICKSCHEDULER_Level_InBus,
        input  SC_LEVELTICKSCHEDULER_Run_in,
        output SC_LEVELTICKSCHEDULER_MoveTick_out,
        output SC_LEVELTICKSCHEDULER_LevelUp_out,
        output SC_LEVELTICKSCHEDULER_Banner_out,
        output SC_LEVELTICKSCHEDULER_Period_OutBus
    );
endinterface

// File: rtl/sc_level_tick_scheduler.sv
// Level-driven move-tick generator: period shrinks with level down to a floor,
// level increases raise a one-cycle pulse and a banner held for BANNER_TICKS ticks.
module sc_level_tick_scheduler #(
    parameter int unsigned LEVEL_DATAWIDTH = 5,
    parameter int unsigned PERIOD_WIDTH    = 26,
    parameter int unsigned BASE_PERIOD     = 25000000,
    parameter int unsigned STEP_PERIOD     = 1000000,
    parameter int unsigned MIN_PERIOD      = 2000000,
    parameter int unsigned BANNER_TICKS    = 3
) (
    input logic                    SC_LEVELTICKSCHEDULER_CLOCK_50,
    input logic                    SC_LEVELTICKSCHEDULER_RESET_InHigh,
    sc_level_tick_scheduler_if.slave bus
);

    localparam int unsigned PROD_W = PERIOD_WIDTH + LEVEL_DATAWIDTH;
    localparam int unsigned BAN_W  = $clog2(BANNER_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BANNER
    } state_t;

    state_t                     state_q;
    logic [PERIOD_WIDTH-1:0]    cnt_q;
    logic [PERIOD_WIDTH-1:0]    period_q;
    logic [LEVEL_DATAWIDTH-1:0] level_q;
    logic [BAN_W-1:0]           banner_cnt_q;
    logic                       move_tick_q;
    logic                       level_up_q;
    logic                       banner_q;

    logic [PROD_W-1:0]          prod_c;
    logic [PERIOD_WIDTH-1:0]    target_d;
    logic                       level_up_c;
    logic                       level_dn_c;
    logic                       wrap_c;

    // Compare against the headroom before subtracting so high levels never underflow.
    always_comb begin
        prod_c = PROD_W'(bus.SC_LEVELTICKSCHEDULER_Level_InBus) * PROD_W'(STEP_PERIOD);
        if (prod_c >= PROD_W'(BASE_PERIOD - MIN_PERIOD)) begin
            target_d = PERIOD_WIDTH'(MIN_PERIOD);
        end else begin
            target_d = PERIOD_WIDTH'(PROD_W'(BASE_PERIOD) - prod_c);
        end
        level_up_c = bus.SC_LEVELTICKSCHEDULER_Run_in &&
                     (bus.SC_LEVELTICKSCHEDULER_Level_InBus > level_q);
        level_dn_c = bus.SC_LEVELTICKSCHEDULER_Level_InBus < level_q;
        wrap_c     = (cnt_q == period_q - PERIOD_WIDTH'(1));
    end

    always_ff @(posedge SC_LEVELTICKSCHEDULER_CLOCK_50) begin
        if (SC_LEVELTICKSCHEDULER_RESET_InHigh) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            period_q     <= PERIOD_WIDTH'(BASE_PERIOD);
            level_q      <= '0;
            banner_cnt_q <= '0;
            move_tick_q  <= 1'b0;
            level_up_q   <= 1'b0;
            banner_q     <= 1'b0;
        end else begin
            level_q     <= bus.SC_LEVELTICKSCHEDULER_Level_InBus;
            level_up_q  <= level_up_c;
            move_tick_q <= 1'b0;

            if (!bus.SC_LEVELTICKSCHEDULER_Run_in) begin
                state_q      <= ST_IDLE;
                cnt_q        <= '0;
                banner_cnt_q <= '0;
                banner_q     <= 1'b0;
                if (state_q == ST_IDLE) begin
                    period_q <= target_d;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q    <= '0;
                        period_q <= target_d;
                        if (level_up_c) begin
                            state_q      <= ST_BANNER;
                            banner_cnt_q <= BAN_W'(BANNER_TICKS);
                            banner_q     <= 1'b1;
                        end else begin
                            state_q      <= ST_RUN;
                            banner_cnt_q <= '0;
                            banner_q     <= 1'b0;
                        end
                    end

                    ST_RUN, ST_BANNER: begin
                        // New period is only picked up at the wrap, never mid-period.
                        if (wrap_c) begin
                            cnt_q       <= '0;
                            move_tick_q <= 1'b1;
                            period_q    <= target_d;
                        end else begin
                            cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                        end

                        // A reload on the wrap cycle takes priority over the decrement.
                        if (level_up_c) begin
                            state_q      <= ST_BANNER;
                            banner_cnt_q <= BAN_W'(BANNER_TICKS);
                            banner_q     <= 1'b1;
                        end else if (level_dn_c) begin
                            state_q      <= ST_RUN;
                            banner_cnt_q <= '0;
                            banner_q     <= 1'b0;
                        end else if ((state_q == ST_BANNER) && wrap_c) begin
                            if (banner_cnt_q <= BAN_W'(1)) begin
                                state_q      <= ST_RUN;
                                banner_cnt_q <= '0;
                                banner_q     <= 1'b0;
                            end else begin
                                banner_cnt_q <= banner_cnt_q - BAN_W'(1);
                            end
                        end
                    end

                    default: begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= '0;
                        banner_cnt_q <= '0;
                        banner_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.SC_LEVELTICKSCHEDULER_MoveTick_out  = move_tick_q;
    assign bus.SC_LEVELTICKSCHEDULER_LevelUp_out   = level_up_q;
    assign bus.SC_LEVELTICKSCHEDULER_Banner_out    = banner_q;
    assign bus.SC_LEVELTICKSCHEDULER_Period_OutBus = period_q;

endmodule

// File: tb/tb_sc_level_tick_scheduler.sv
// Bench for sc_level_tick_scheduler: deadline-based reference model feeding a
// per-cycle scoreboard, plus directed checks on tick spacing, clamping and banner.
module tb_sc_level_tick_scheduler;

    localparam int unsigned LW   = 5;
    localparam int unsigned PW   = 26;
    localparam int unsigned BASE = 10;
    localparam int unsigned STEP = 2;
    localparam int unsigned MINP = 4;
    localparam int unsigned BT   = 2;

    typedef struct packed {
        logic          tick;
        logic          up;
        logic          ban;
        logic [PW-1:0] per;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sc_level_tick_scheduler_if #(.LEVEL_DATAWIDTH(LW), .PERIOD_WIDTH(PW)) bus ();

    sc_level_tick_scheduler #(
        .LEVEL_DATAWIDTH(LW),
        .PERIOD_WIDTH   (PW),
        .BASE_PERIOD    (BASE),
        .STEP_PERIOD    (STEP),
        .MIN_PERIOD     (MINP),
        .BANNER_TICKS   (BT)
    ) dut (
        .SC_LEVELTICKSCHEDULER_CLOCK_50    (clk),
        .SC_LEVELTICKSCHEDULER_RESET_InHigh(rst),
        .bus                               (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned tgt(input int unsigned l);
        if (l * STEP >= BASE - MINP) return MINP;
        return BASE - l * STEP;
    endfunction

    // Reference model: tracks the absolute cycle of the next tick instead of a counter.
    bit          m_running = 1'b0;
    bit          m_ban     = 1'b0;
    bit          m_up      = 1'b0;
    bit          m_dn      = 1'b0;
    bit          m_tick    = 1'b0;
    int unsigned m_left    = 0;
    int unsigned m_per     = BASE;
    int unsigned m_prev    = 0;
    int          m_next    = 0;

    always @(posedge clk) begin
        int unsigned lvl;
        bit          run;
        cyc++;
        lvl = int'(bus.SC_LEVELTICKSCHEDULER_Level_InBus);
        run = bus.SC_LEVELTICKSCHEDULER_Run_in;
        m_tick = 1'b0;
        if (rst) begin
            m_running = 1'b0;
            m_ban     = 1'b0;
            m_up      = 1'b0;
            m_left    = 0;
            m_per     = BASE;
            m_prev    = 0;
        end else begin
            m_up = run && (lvl > m_prev);
            m_dn = lvl < m_prev;
            if (!run) begin
                if (!m_running) m_per = tgt(lvl);
                m_running = 1'b0;
                m_ban     = 1'b0;
                m_left    = 0;
            end else if (!m_running) begin
                m_per     = tgt(lvl);
                m_running = 1'b1;
                m_next    = cyc + int'(m_per);
                if (m_up) begin
                    m_ban  = 1'b1;
                    m_left = BT;
                end
            end else begin
                if (cyc == m_next) begin
                    m_tick = 1'b1;
                    m_per  = tgt(lvl);
                    m_next = cyc + int'(m_per);
                end
                if (m_up) begin
                    m_ban  = 1'b1;
                    m_left = BT;
                end else if (m_dn) begin
                    m_ban  = 1'b0;
                    m_left = 0;
                end else if (m_tick && m_ban) begin
                    m_left--;
                    if (m_left == 0) m_ban = 1'b0;
                end
            end
            m_prev = lvl;
        end
        sb_q.push_back('{tick: m_tick, up: m_up, ban: m_ban, per: PW'(m_per)});
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_tick",   bus.SC_LEVELTICKSCHEDULER_MoveTick_out,  e.tick);
            check("sb_levelup", bus.SC_LEVELTICKSCHEDULER_LevelUp_out,  e.up);
            check("sb_banner", bus.SC_LEVELTICKSCHEDULER_Banner_out,    e.ban);
            check("sb_period", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, e.per);
        end
    end

    task automatic wait_tick(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.SC_LEVELTICKSCHEDULER_MoveTick_out) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("tick_timeout", 0, 1);
    endtask

    task automatic set_level(input int unsigned l);
        bus.SC_LEVELTICKSCHEDULER_Level_InBus = LW'(l);
    endtask

    initial begin
        int t0;
        int t1;
        bus.SC_LEVELTICKSCHEDULER_Run_in = 1'b0;
        set_level(0);
        repeat (3) @(negedge clk);
        check("rst_period",  bus.SC_LEVELTICKSCHEDULER_Period_OutBus, BASE);
        check("rst_tick",    bus.SC_LEVELTICKSCHEDULER_MoveTick_out, 0);
        check("rst_banner",  bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);
        check("rst_levelup", bus.SC_LEVELTICKSCHEDULER_LevelUp_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Level 0: ticks every BASE cycles after entering RUN.
        bus.SC_LEVELTICKSCHEDULER_Run_in = 1'b1;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_tick(t1);
            check("t1_spacing", longint'(t1 - t0), BASE);
            t0 = t1;
        end
        check("t1_period", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, BASE);

        // Level-up mid-period: old period finishes, then spacing 6, banner for 2 ticks.
        repeat (3) @(negedge clk);
        set_level(2);
        @(negedge clk);
        check("t2_levelup_pulse", bus.SC_LEVELTICKSCHEDULER_LevelUp_out, 1);
        check("t2_banner_on",     bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        @(negedge clk);
        check("t2_levelup_end", bus.SC_LEVELTICKSCHEDULER_LevelUp_out, 0);
        wait_tick(t1);
        check("t2_old_spacing", longint'(t1 - t0), BASE);
        check("t2_new_period",  bus.SC_LEVELTICKSCHEDULER_Period_OutBus, 6);
        check("t2_banner_tick1", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        t0 = t1;
        wait_tick(t1);
        check("t2_new_spacing",  longint'(t1 - t0), 6);
        check("t2_banner_tick2", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);

        // Clamp at the floor, including the all-ones level.
        set_level(5);
        wait_tick(t1);
        check("t3_clamp5", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, MINP);
        t0 = t1;
        wait_tick(t1);
        check("t3_spacing5", longint'(t1 - t0), MINP);
        set_level(31);
        wait_tick(t1);
        t0 = t1;
        wait_tick(t1);
        check("t3_spacing31", longint'(t1 - t0), MINP);
        check("t3_clamp31",   bus.SC_LEVELTICKSCHEDULER_Period_OutBus, MINP);

        // Wrap to 0, then a second level-up inside the banner window reloads it.
        set_level(0);
        repeat (2) @(negedge clk);
        check("t4_banner_off", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);
        wait_tick(t1);
        check("t4_period_l0", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, BASE);
        set_level(1);
        @(negedge clk);
        check("t4_banner_on", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        wait_tick(t1);
        check("t4_banner_1tick", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        set_level(2);
        repeat (2) @(negedge clk);
        wait_tick(t1);
        check("t4_banner_reload", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        wait_tick(t1);
        check("t4_banner_done", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);

        // Decrease during banner: no pulse, banner drops next cycle, period back at wrap.
        set_level(3);
        repeat (2) @(negedge clk);
        check("t5_banner_on", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        set_level(0);
        @(negedge clk);
        check("t5_no_levelup",  bus.SC_LEVELTICKSCHEDULER_LevelUp_out, 0);
        check("t5_banner_drop", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);
        wait_tick(t1);
        check("t5_period_back", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, BASE);

        // Halt mid-banner, restart, then reset mid-banner.
        set_level(1);
        repeat (3) @(negedge clk);
        bus.SC_LEVELTICKSCHEDULER_Run_in = 1'b0;
        @(negedge clk);
        check("t6_halt_banner", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_halt_tick", bus.SC_LEVELTICKSCHEDULER_MoveTick_out, 0);
        end
        bus.SC_LEVELTICKSCHEDULER_Run_in = 1'b1;
        @(negedge clk);
        t0 = cyc;
        wait_tick(t1);
        check("t6_restart_spacing", longint'(t1 - t0), 8);
        set_level(4);
        repeat (2) @(negedge clk);
        check("t6_banner_pre_rst", bus.SC_LEVELTICKSCHEDULER_Banner_out, 1);
        rst = 1'b1;
        set_level(0);
        @(negedge clk);
        check("t6_rst_banner", bus.SC_LEVELTICKSCHEDULER_Banner_out, 0);
        check("t6_rst_tick",   bus.SC_LEVELTICKSCHEDULER_MoveTick_out, 0);
        check("t6_rst_period", bus.SC_LEVELTICKSCHEDULER_Period_OutBus, BASE);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        t0 = cyc;
        wait_tick(t1);
        check("t6_post_rst_spacing", longint'(t1 - t0), BASE);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
